// File: rtl/imem_refill_pkg.sv
// Shared definitions for the I-cache line refill engine.
// Holds the default line/bus/block-address widths, the beat-offset width helper and the
// refill FSM state encoding. Optional macro IMEM_REFILL_PREFETCH_EN adds the S_PF state.
package imem_refill_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned BUS_W_DEF   = 64;
  localparam int unsigned BLK_LEN_DEF = 59;

  // Beat counter width; a single-beat line still gets a 1-bit counter that never leaves 0.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

`ifdef IMEM_REFILL_PREFETCH_EN
  typedef enum logic [2:0] {S_IDLE, S_BEAT, S_DONE, S_DRAIN, S_PF} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE, S_DRAIN} state_e;
`endif

endpackage

// File: rtl/imem_refill_pfb.sv
// Next-line prefetch buffer: one line of data with its block tag and a valid bit.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         capture load_tag/load_line and mark valid
//   clr          invalidate (wins over load)
//   lookup_addr  block address compared against the stored tag
//   hit          valid && tag == lookup_addr
//   line         buffered line data
module imem_refill_pfb
  import imem_refill_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned BLK_LEN = BLK_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clr,
  input  logic [BLK_LEN-1:0] load_tag,
  input  logic [LINE_W-1:0]  load_line,
  input  logic [BLK_LEN-1:0] lookup_addr,
  output logic               hit,
  output logic [LINE_W-1:0]  line
);

  logic               valid_q;
  logic [BLK_LEN-1:0] tag_q;
  logic [LINE_W-1:0]  line_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= load_tag;
      line_q  <= load_line;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_addr);
  assign line = line_q;

endmodule

// File: rtl/imem_refill.sv
// I-cache line refill engine. Takes a level-held line-miss request, issues BEATS sequential
// beat reads on the memory bus, assembles them little-endian and returns the line with a
// one-cycle b_dv_i pulse.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   b_addr_i, b_rd_i    line block address and request (held until b_dv_i)
//   b_data_i, b_dv_i    assembled line and its one-cycle valid (outputs)
//   fence_i             instruction fence; drops prefetch state only
//   m_addr, m_req       beat byte address and read request
//   m_ack, m_rdata      beat accept with same-cycle read data
// Optional macro IMEM_REFILL_PREFETCH_EN: after a delivered line, prefetch the next block
// into a one-line buffer (imem_refill_pfb).
module imem_refill
  import imem_refill_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned BUS_W   = BUS_W_DEF,
  parameter int unsigned BLK_LEN = BLK_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_i,
  input  logic               b_rd_i,
  output logic [LINE_W-1:0]  b_data_i,
  output logic               b_dv_i,
  input  logic               fence_i,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_req,
  input  logic               m_ack,
  input  logic [BUS_W-1:0]   m_rdata
);

  localparam int unsigned BEATS   = LINE_W / BUS_W;
  localparam int unsigned CNT_W   = cnt_width(BEATS);
  localparam int unsigned BYTE_SH = $clog2(BUS_W / 8);
  localparam int unsigned LINE_SH = $clog2(LINE_W / 8);

  state_e             state_q, state_d;
  logic [BLK_LEN-1:0] blk_q, blk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef IMEM_REFILL_PREFETCH_EN
  logic               pf_load, pf_clr, pf_hit;
  logic [LINE_W-1:0]  pf_line;
  // Armed after each delivered line: next block still to be prefetched.
  logic               pf_pend_q, pf_pend_d;
  logic [BLK_LEN-1:0] pf_next_q, pf_next_d;

  imem_refill_pfb #(
    .LINE_W (LINE_W),
    .BLK_LEN(BLK_LEN)
  ) u_pfb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pf_load),
    .clr        (pf_clr),
    .load_tag   (blk_q),
    .load_line  (line_d),
    .lookup_addr(b_addr_i),
    .hit        (pf_hit),
    .line       (pf_line)
  );
`else
  logic unused_fence;
  assign unused_fence = fence_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
`ifdef IMEM_REFILL_PREFETCH_EN
      pf_pend_q <= 1'b0;
      pf_next_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
`ifdef IMEM_REFILL_PREFETCH_EN
      pf_pend_q <= pf_pend_d;
      pf_next_q <= pf_next_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
`ifdef IMEM_REFILL_PREFETCH_EN
    pf_load   = 1'b0;
    pf_clr    = 1'b0;
    pf_pend_d = pf_pend_q;
    pf_next_d = pf_next_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (b_rd_i) begin
          blk_d = b_addr_i;
          cnt_d = '0;
`ifdef IMEM_REFILL_PREFETCH_EN
          pf_pend_d = 1'b0;
          if (pf_hit && !fence_i) begin
            line_d  = pf_line;
            pf_clr  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BEAT;
          end
        end else if (pf_pend_q && !fence_i) begin
          // Buffer is about to be overwritten, so drop its old contents now.
          blk_d     = pf_next_q;
          cnt_d     = '0;
          pf_pend_d = 1'b0;
          pf_clr    = 1'b1;
          state_d   = S_PF;
`else
          state_d = S_BEAT;
`endif
        end
      end
      S_BEAT: begin
        if (!b_rd_i) begin
          // Abort: a beat accepted this cycle needs no drain.
          state_d = m_ack ? S_IDLE : S_DRAIN;
        end else if (m_ack) begin
          line_d[cnt_q*BUS_W +: BUS_W] = m_rdata;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef IMEM_REFILL_PREFETCH_EN
        pf_pend_d = 1'b1;
        pf_next_d = blk_q + BLK_LEN'(1);
`endif
      end
      S_DRAIN: begin
        if (m_ack) state_d = S_IDLE;
      end
`ifdef IMEM_REFILL_PREFETCH_EN
      S_PF: begin
        if (fence_i || (b_rd_i && (b_addr_i != blk_q))) begin
          state_d = m_ack ? S_IDLE : S_DRAIN;
        end else begin
          if (m_ack) begin
            line_d[cnt_q*BUS_W +: BUS_W] = m_rdata;
            cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          end
          if (m_ack && last_beat) begin
            if (b_rd_i) begin
              state_d = S_DONE;
            end else begin
              pf_load = 1'b1;
              state_d = S_IDLE;
            end
          end else if (b_rd_i) begin
            // Demand for the block being prefetched: keep going as a demand refill.
            state_d = S_BEAT;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef IMEM_REFILL_PREFETCH_EN
    if (fence_i) begin
      pf_clr    = 1'b1;
      pf_load   = 1'b0;
      pf_pend_d = 1'b0;
    end
`endif
  end

`ifdef IMEM_REFILL_PREFETCH_EN
  assign m_req = (state_q == S_BEAT) || (state_q == S_DRAIN) || (state_q == S_PF);
`else
  assign m_req = (state_q == S_BEAT) || (state_q == S_DRAIN);
`endif

  assign m_addr   = m_req ? (ADDR_W'({blk_q, {LINE_SH{1'b0}}}) | (ADDR_W'(cnt_q) << BYTE_SH))
                          : '0;
  assign b_dv_i   = (state_q == S_DONE);
  assign b_data_i = b_dv_i ? line_q : '0;

endmodule

// File: tb/tb_imem_refill.sv
`timescale 1ns/1ps
module tb_imem_refill;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BUS_W   = 64;
  localparam int unsigned BLK_LEN = 59;
  localparam int unsigned BEATS   = LINE_W / BUS_W;
  localparam int unsigned LINE_SH = $clog2(LINE_W / 8);
`ifdef IMEM_REFILL_PREFETCH_EN
  localparam int IDLE_CHECKS = 1;  // a prefetch legitimately starts right after
`else
  localparam int IDLE_CHECKS = 3;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [BLK_LEN-1:0] b_addr = '0;
  logic               b_rd = 1'b0;
  logic [LINE_W-1:0]  b_data;
  logic               b_dv;
  logic               fence = 1'b0;
  logic [63:0]        m_addr;
  logic               m_req;
  logic               m_ack = 1'b0;
  logic [BUS_W-1:0]   m_rdata = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imem_refill dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .b_addr_i(b_addr),
    .b_rd_i  (b_rd),
    .b_data_i(b_data),
    .b_dv_i  (b_dv),
    .fence_i (fence),
    .m_addr  (m_addr),
    .m_req   (m_req),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  // Backing memory contents: a fixed function of the byte address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC001_D00D, a[63:32] + a[31:0] * 32'h9E37_79B9};
  endfunction

  function automatic logic [63:0] line_base(input logic [BLK_LEN-1:0] blk);
    return 64'(blk) << LINE_SH;
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input logic [BLK_LEN-1:0] blk);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < int'(BEATS); i++) l[i*BUS_W +: BUS_W] = mem_word(line_base(blk) + 64'(i * 8));
    return l;
  endfunction

  function automatic logic [BLK_LEN-1:0] rand_blk();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[BLK_LEN-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; b_rd = 1'b0; m_ack = 1'b0; fence = 1'b0; m_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Demand refill against a memory that accepts each beat after 0..max_wait idle cycles.
  task automatic run_refill(input logic [BLK_LEN-1:0] blk, input int max_wait, output int dv_step);
    logic [63:0]       base, exp_addr;
    logic [LINE_W-1:0] line;
    int acked, wait_left, steps, idle_after;
    bit dv_seen, exp_req, exp_dv;
    base = line_base(blk);
    line = exp_line(blk);
    acked = 0; steps = 0; idle_after = 0; dv_seen = 0; dv_step = -1;
    wait_left = $urandom_range(max_wait, 0);
    b_addr = blk; b_rd = 1'b1; m_ack = 1'b0;
    while (idle_after < IDLE_CHECKS && steps < 100) begin
      tick();
      steps++;
      exp_req  = (acked < int'(BEATS));
      exp_dv   = (acked == int'(BEATS)) && !dv_seen;
      exp_addr = base + 64'(acked * 8);
      tests_run++;
      if (m_req !== exp_req) begin
        tests_failed++;
        $display("FAIL refill_m_req blk=%h step=%0d got %b want %b", blk, steps, m_req, exp_req);
      end
      tests_run++;
      if (b_dv !== exp_dv) begin
        tests_failed++;
        $display("FAIL refill_b_dv blk=%h step=%0d got %b want %b", blk, steps, b_dv, exp_dv);
      end
      if (exp_req) begin
        tests_run++;
        if (m_addr !== exp_addr) begin
          tests_failed++;
          $display("FAIL refill_m_addr blk=%h step=%0d got %h want %h", blk, steps, m_addr, exp_addr);
        end
      end
      if (exp_dv) begin
        dv_step = steps;
        tests_run++;
        if (b_data !== line) begin
          tests_failed++;
          $display("FAIL refill_b_data blk=%h got %h want %h", blk, b_data, line);
        end
      end
      // The cache drops its request the cycle after it sees the line.
      if (dv_seen) begin
        b_rd = 1'b0;
        idle_after++;
      end
      if (exp_dv) dv_seen = 1'b1;
      if (exp_req) begin
        if (wait_left == 0) begin
          m_ack = 1'b1;
          m_rdata = mem_word(exp_addr);
          acked++;
          wait_left = $urandom_range(max_wait, 0);
        end else begin
          m_ack = 1'b0;
          m_rdata = {$urandom, $urandom};
          wait_left--;
        end
      end else begin
        m_ack = 1'($urandom_range(1, 0));  // stray acks must be ignored
        m_rdata = {$urandom, $urandom};
      end
    end
    if (!dv_seen) begin
      tests_failed++;
      $display("FAIL refill_timeout blk=%h got no b_dv want one pulse", blk);
    end
    b_rd = 1'b0;
    m_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b_rd = 1'b1; b_addr = rand_blk(); m_ack = 1'b1;
    tick();
    tick();
    tests_run++;
    if (b_dv !== 1'b0) begin tests_failed++; $display("FAIL reset_b_dv got %b want 0", b_dv); end
    tests_run++;
    if (b_data !== '0) begin tests_failed++; $display("FAIL reset_b_data got %h want 0", b_data); end
    tests_run++;
    if (m_req !== 1'b0) begin tests_failed++; $display("FAIL reset_m_req got %b want 0", m_req); end
    tests_run++;
    if (m_addr !== 64'h0) begin tests_failed++; $display("FAIL reset_m_addr got %h want 0", m_addr); end
    b_rd = 1'b0; m_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    int s;
    apply_reset();
    run_refill(59'h10, 0, s);
    tests_run++;
    if (s != int'(BEATS) + 1) begin
      tests_failed++;
      $display("FAIL zero_wait_latency got %0d want %0d", s, BEATS + 1);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
`ifdef IMEM_REFILL_PREFETCH_EN
      apply_reset();
`endif
      run_refill((i == 5) ? {BLK_LEN{1'b1}} : rand_blk(), 3, s);
    end
  endtask

  task automatic test_abort();
    logic [BLK_LEN-1:0] blk;
    logic [63:0] base;
    apply_reset();
    blk = rand_blk();
    base = line_base(blk);
    b_addr = blk; b_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (m_req !== 1'b1 || m_addr !== base + 64'(i * 8)) begin
        tests_failed++;
        $display("FAIL abort_beat%0d got req=%b addr=%h want req=1 addr=%h", i, m_req, m_addr,
                 base + 64'(i * 8));
      end
      m_ack = (i < 2);
      m_rdata = mem_word(base + 64'(i * 8));
    end
    b_rd = 1'b0;  // beat 2 still pending
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (m_req !== 1'b1 || m_addr !== base + 64'd16 || b_dv !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_drain%0d got req=%b addr=%h dv=%b want req=1 addr=%h dv=0", i, m_req,
                 m_addr, b_dv, base + 64'd16);
      end
      m_ack = (i == 2);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (m_req !== 1'b0 || b_dv !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_idle%0d got req=%b dv=%b want req=0 dv=0", i, m_req, b_dv);
      end
      m_ack = 1'($urandom_range(1, 0));
    end
    m_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    b_addr = rand_blk(); b_rd = 1'b1;
    tick();
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (m_req !== 1'b0 || b_dv !== 1'b0 || m_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_mid got req=%b dv=%b addr=%h want req=0 dv=0 addr=0", m_req, b_dv, m_addr);
    end
    rst_n = 1'b1; b_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_ack = 1'b1;
      m_rdata = {$urandom, $urandom};
      tick();
      tests_run++;
      if (m_req !== 1'b0 || b_dv !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_stray_ack%0d got req=%b dv=%b want req=0 dv=0", i, m_req, b_dv);
      end
    end
    m_ack = 1'b0;
  endtask

`ifdef IMEM_REFILL_PREFETCH_EN
  task automatic test_pf_wrap();
    int s;
    apply_reset();
    run_refill({BLK_LEN{1'b1}}, 0, s);
    for (int i = 0; i < int'(BEATS); i++) begin
      tick();
      tests_run++;
      if (m_req !== 1'b1 || m_addr !== 64'(i * 8)) begin
        tests_failed++;
        $display("FAIL pf_wrap_beat%0d got req=%b addr=%h want req=1 addr=%h", i, m_req, m_addr,
                 64'(i * 8));
      end
      m_ack = 1'b1;
      m_rdata = mem_word(64'(i * 8));
    end
    tick();
    m_ack = 1'b0;
    tests_run++;
    if (m_req !== 1'b0) begin tests_failed++; $display("FAIL pf_wrap_idle got req=%b want 0", m_req); end
    b_addr = '0; b_rd = 1'b1;
    tick();
    tests_run++;
    if (b_dv !== 1'b1 || b_data !== exp_line('0)) begin
      tests_failed++;
      $display("FAIL pf_wrap_hit got dv=%b data=%h want dv=1 data=%h", b_dv, b_data, exp_line('0));
    end
    b_rd = 1'b0;
  endtask

  task automatic test_pf_fence();
    int s;
    logic [BLK_LEN-1:0] nb;
    logic [63:0] base;
    apply_reset();
    run_refill(59'h40, 0, s);
    nb = 59'h41;
    base = line_base(nb);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (m_req !== 1'b1 || m_addr !== base + 64'(i * 8)) begin
        tests_failed++;
        $display("FAIL pf_fence_beat%0d got req=%b addr=%h want req=1 addr=%h", i, m_req, m_addr,
                 base + 64'(i * 8));
      end
      m_ack = (i < 2);
      m_rdata = mem_word(base + 64'(i * 8));
    end
    fence = 1'b1;
    tick();
    fence = 1'b0;
    tests_run++;
    if (m_req !== 1'b1 || m_addr !== base + 64'd16) begin
      tests_failed++;
      $display("FAIL pf_fence_drain got req=%b addr=%h want req=1 addr=%h", m_req, m_addr,
               base + 64'd16);
    end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tests_run++;
    if (m_req !== 1'b0) begin tests_failed++; $display("FAIL pf_fence_idle got req=%b want 0", m_req); end
    run_refill(nb, 0, s);
    tests_run++;
    if (s != int'(BEATS) + 1) begin
      tests_failed++;
      $display("FAIL pf_fence_latency got %0d want %0d", s, BEATS + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef IMEM_REFILL_PREFETCH_EN
    test_pf_wrap();
    test_pf_fence();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
